// File: rtl/sprite_table_sync.sv
// Per-frame BRAM port-B sequencer: during vblank it optionally writes the player back,
// re-reads the sprite table into shadow registers and commits them atomically to the active set.
module sprite_table_sync #(
   parameter int MAX_OBS     = 15,
   parameter int TABLE_BASE  = 0,
   parameter int VBLANK_LINE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic [15:0] q_b,
   output logic [9:0]  addr_b,
   output logic [15:0] data_b,
   output logic        we_b,
   input  logic        wb_en,
   input  logic [9:0]  player_x_in,
   input  logic [9:0]  player_y_in,
   input  logic [3:0]  obs_idx,
   output logic [9:0]  obs_x,
   output logic [9:0]  obs_y,
   output logic        obs_valid,
   output logic [9:0]  player_x,
   output logic [9:0]  player_y,
   output logic [4:0]  sprite_count,
   output logic        table_valid,
   output logic        overflow,
   output logic        busy,
   output logic        sync_done
);

   localparam int         SLOTS   = 16;
   localparam logic [4:0] EFF_MAX = 5'(MAX_OBS + 1);
   localparam logic [9:0] BASE    = 10'(TABLE_BASE);
   localparam logic [9:0] VB_LINE = 10'(VBLANK_LINE);

   typedef enum logic [2:0] {
      S_IDLE, S_WB_X, S_WB_Y, S_RD_CNT, S_CAP_CNT, S_RD_XY, S_COMMIT
   } state_t;

   state_t      state, state_nxt;
   logic [9:0]  addr_nxt;
   logic [15:0] data_nxt;
   logic        we_nxt;
   logic        fired;
   logic        trigger;
   logic        over_cap;
   logic [4:0]  eff, eff_cap;
   logic [5:0]  word_k, last_k;
   logic [4:0]  sprite;
   logic [3:0]  slot;

   logic [9:0]  sh_px, sh_py;
   logic [9:0]  sh_ox [SLOTS];
   logic [9:0]  sh_oy [SLOTS];
   logic [9:0]  act_ox [SLOTS];
   logic [9:0]  act_oy [SLOTS];

   // fired blocks a second trigger until vCount leaves the vblank start line
   assign trigger  = (hCount == 10'd0) && (vCount == VB_LINE) && !fired;
   assign over_cap = q_b > 16'(MAX_OBS + 1);
   assign eff_cap  = over_cap ? EFF_MAX : q_b[4:0];
   assign last_k   = {eff, 1'b0} - 6'd1;
   assign sprite   = word_k[5:1];
   assign slot     = 4'(sprite - 5'd1);

   assign busy      = (state != S_IDLE);
   assign sync_done = (state == S_COMMIT);
   assign obs_valid = table_valid && (({1'b0, obs_idx} + 5'd1) < sprite_count);
   assign obs_x     = obs_valid ? act_ox[obs_idx] : 10'd0;
   assign obs_y     = obs_valid ? act_oy[obs_idx] : 10'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Port-B outputs are registered: the values chosen here are presented during the next state.
   // Word k+1 is addressed while word k is captured, giving one word per cycle.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_b;
      data_nxt  = 16'd0;
      we_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               if (wb_en) begin
                  state_nxt = S_WB_X;
                  addr_nxt  = BASE + 10'd1;
                  data_nxt  = {6'b0, player_x_in};
                  we_nxt    = 1'b1;
               end else begin
                  state_nxt = S_RD_CNT;
                  addr_nxt  = BASE;
               end
            end
         end
         S_WB_X: begin
            state_nxt = S_WB_Y;
            addr_nxt  = BASE + 10'd2;
            data_nxt  = {6'b0, player_y_in};
            we_nxt    = 1'b1;
         end
         S_WB_Y: begin
            state_nxt = S_RD_CNT;
            addr_nxt  = BASE;
         end
         S_RD_CNT: begin
            state_nxt = S_CAP_CNT;
            addr_nxt  = BASE + 10'd1;
         end
         S_CAP_CNT: begin
            if (eff_cap == 5'd0) begin
               state_nxt = S_COMMIT;
            end else begin
               state_nxt = S_RD_XY;
               addr_nxt  = BASE + 10'd2;
            end
         end
         S_RD_XY: begin
            if (word_k == last_k) state_nxt = S_COMMIT;
            else if ((word_k + 6'd2) <= last_k) addr_nxt = BASE + 10'(word_k) + 10'd3;
         end
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_b       <= '0;
         data_b       <= '0;
         we_b         <= 1'b0;
         fired        <= 1'b0;
         eff          <= '0;
         word_k       <= '0;
         overflow     <= 1'b0;
         sh_px        <= '0;
         sh_py        <= '0;
         player_x     <= '0;
         player_y     <= '0;
         sprite_count <= '0;
         table_valid  <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            sh_ox[i]  <= '0;
            sh_oy[i]  <= '0;
            act_ox[i] <= '0;
            act_oy[i] <= '0;
         end
      end else begin
         addr_b <= addr_nxt;
         data_b <= data_nxt;
         we_b   <= we_nxt;
         if (vCount != VB_LINE)               fired <= 1'b0;
         else if (state == S_IDLE && trigger) fired <= 1'b1;
         case (state)
            S_CAP_CNT: begin
               eff    <= eff_cap;
               word_k <= '0;
               if (over_cap) overflow <= 1'b1;
            end
            S_RD_XY: begin
               word_k <= word_k + 6'd1;
               if (sprite == 5'd0) begin
                  if (!word_k[0]) sh_px <= q_b[9:0];
                  else            sh_py <= q_b[9:0];
               end else begin
                  if (!word_k[0]) sh_ox[slot] <= q_b[9:0];
                  else            sh_oy[slot] <= q_b[9:0];
               end
            end
            S_COMMIT: begin
               // Slots past this frame's count hold stale shadow data, so they are zeroed here
               player_x     <= (eff != 5'd0) ? sh_px : 10'd0;
               player_y     <= (eff != 5'd0) ? sh_py : 10'd0;
               sprite_count <= eff;
               table_valid  <= 1'b1;
               for (int i = 0; i < SLOTS; i++) begin
                  if (5'(i + 1) < eff) begin
                     act_ox[i] <= sh_ox[i];
                     act_oy[i] <= sh_oy[i];
                  end else begin
                     act_ox[i] <= '0;
                     act_oy[i] <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
